mem_bus_arbiter: RTL

//  Shares one memory bus between instruction fetch (I port) and the memory stage (D port).
//  One transaction is outstanding at a time; the request is latched, driven to the bus, and the

---
 rtl/mem_bus_arbiter_if.sv | 54 +++++
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle for mem_bus_arbiter: fetch port (ireq/iresp), memory-stage
// port (dreq/dresp) and the shared memory bus. The arbiter connects through
// the master modport; the pipeline stages and bus use the slave modport.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Instruction fetch port
    logic                  ireq_valid;
    logic [ADDR_W-1:0]     ireq_addr;
    logic                  ireq_ready;
    logic                  iresp_valid;
    logic [DATA_W-1:0]     iresp_data;

    // Memory-stage data port
    logic                  dreq_valid;
    logic [ADDR_W-1:0]     dreq_addr;
    logic                  dreq_write;
    logic [DATA_W/8-1:0]   dreq_strobe;
    logic [DATA_W-1:0]     dreq_wdata;
    logic                  dreq_ready;
    logic                  dresp_valid;
    logic [DATA_W-1:0]     dresp_data;

    // Shared memory bus
    logic                  bus_valid;
    logic [ADDR_W-1:0]     bus_addr;
    logic                  bus_write;
    logic [DATA_W/8-1:0]   bus_strobe;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_ready;
    logic                  bus_resp_valid;
    logic [DATA_W-1:0]     bus_resp_data;

    // Arbiter view
    modport master (
        input  ireq_valid, ireq_addr,
        output ireq_ready, iresp_valid, iresp_data,
        input  dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
        output dreq_ready, dresp_valid, dresp_data,
        output bus_valid, bus_addr, bus_write, bus_strobe, bus_wdata,
        input  bus_ready, bus_resp_valid, bus_resp_data
    );

    // Pipeline-stage and bus view
    modport slave (
        output ireq_valid, ireq_addr,
        input  ireq_ready, iresp_valid, iresp_data,
        output dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
        input  dreq_ready, dresp_valid, dresp_data,
        input  bus_valid, bus_addr, bus_write, bus_strobe, bus_wdata,
        output bus_ready, bus_resp_valid, bus_resp_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch (I) and
// the memory stage (D), one transaction outstanding at a time. A granted
// request is latched, presented on the bus until accepted, and the response
// is registered back to its owner.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard (I wins a contest after STARVE_LIMIT D grants while I
// waited). Without it, D has strict priority.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master arb
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                grant_en_q;
    logic                bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_write_q, bus_write_d;
    logic [STRB_W-1:0]   bus_strobe_q, bus_strobe_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                iresp_valid_q, iresp_valid_d;
    logic [DATA_W-1:0]   iresp_data_q, iresp_data_d;
    logic                dresp_valid_q, dresp_valid_d;
    logic [DATA_W-1:0]   dresp_data_q, dresp_data_d;
    logic                grant_i, grant_d;
    logic                starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Count D grants taken while fetch was waiting; saturate at the limit, clear when I is served
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (grant_d && arb.ireq_valid && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Grant decision: only in IDLE, D preferred unless the starvation guard hands the contest to I.
    // grant_en_q keeps the Mealy ready pulses low until the first cycle after reset release.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE && grant_en_q) begin
            grant_i = arb.ireq_valid && (!arb.dreq_valid || starve_hit);
            grant_d = arb.dreq_valid && !grant_i;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d       = state_q;
        bus_valid_d   = bus_valid_q;
        bus_addr_d    = bus_addr_q;
        bus_write_d   = bus_write_q;
        bus_strobe_d  = bus_strobe_q;
        bus_wdata_d   = bus_wdata_q;
        iresp_valid_d = 1'b0;
        iresp_data_d  = iresp_data_q;
        dresp_valid_d = 1'b0;
        dresp_data_d  = dresp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    bus_valid_d  = 1'b1;
                    bus_addr_d   = arb.dreq_addr;
                    bus_write_d  = arb.dreq_write;
                    bus_strobe_d = arb.dreq_strobe;
                    bus_wdata_d  = arb.dreq_wdata;
                    state_d      = REQ_D;
                end else if (grant_i) begin
                    // Fetches are always reads: no write flag, strobe or data on the bus
                    bus_valid_d  = 1'b1;
                    bus_addr_d   = arb.ireq_addr;
                    bus_write_d  = 1'b0;
                    bus_strobe_d = '0;
                    bus_wdata_d  = '0;
                    state_d      = REQ_I;
                end
            end
            REQ_I: begin
                if (arb.bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = WAIT_I;
                end
            end
            REQ_D: begin
                if (arb.bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = WAIT_D;
                end
            end
            WAIT_I: begin
                if (arb.bus_resp_valid) begin
                    iresp_data_d  = arb.bus_resp_data;
                    iresp_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            WAIT_D: begin
                if (arb.bus_resp_valid) begin
                    dresp_data_d  = arb.bus_resp_data;
                    dresp_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                bus_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus request latch, response registers and grant enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_en_q    <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_write_q   <= 1'b0;
            bus_strobe_q  <= '0;
            bus_wdata_q   <= '0;
            iresp_valid_q <= 1'b0;
            iresp_data_q  <= '0;
            dresp_valid_q <= 1'b0;
            dresp_data_q  <= '0;
        end else begin
            grant_en_q    <= 1'b1;
            bus_valid_q   <= bus_valid_d;
            bus_addr_q    <= bus_addr_d;
            bus_write_q   <= bus_write_d;
            bus_strobe_q  <= bus_strobe_d;
            bus_wdata_q   <= bus_wdata_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_data_q  <= iresp_data_d;
            dresp_valid_q <= dresp_valid_d;
            dresp_data_q  <= dresp_data_d;
        end
    end

    // Ready pulses are issued in the IDLE cycle that latches the request
    assign arb.ireq_ready  = grant_i;
    assign arb.dreq_ready  = grant_d;
    assign arb.iresp_valid = iresp_valid_q;
    assign arb.iresp_data  = iresp_data_q;
    assign arb.dresp_valid = dresp_valid_q;
    assign arb.dresp_data  = dresp_data_q;
    assign arb.bus_valid   = bus_valid_q;
    assign arb.bus_addr    = bus_addr_q;
    assign arb.bus_write   = bus_write_q;
    assign arb.bus_strobe  = bus_strobe_q;
    assign arb.bus_wdata   = bus_wdata_q;
endmodule
